df_mac_unit: RTL and testbench
==============================

# df_mac_unit

Dot-product stage that sits directly downstream of the dense-layer weights memory (`df_weights_memory`) in the 1D-CFNN datapath. It walks input addresses 0..N_IN-1 and drives the weights memory enable. For each input it pairs the returned weight `w` with the matching pixel from the input buffer and accumulates the signed products. After the last product it adds a bias, applies an arithmetic shift, an optional ReLU and saturation, and emits one 16-bit neuron output with a single-cycle valid pulse.

## Interface
- `N_IN`, 10, number of inputs per dot product (1..2^ADDR_W)
- `ADDR_W`, 4, width of `addr`
- `ACC_W`, 40, accumulator width (signed)
- `FRAC`, 8, arithmetic right-shift applied to (acc + bias) before saturation
- `RELU`, 1, 1 = clamp negative results to 0; 0 = pass through
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request one dot product; sampled only in IDLE
- `bias`  in  16 signed  bias in output Q-format; captured when `start` is accepted
- `w`  in  16 signed  weight from weights memory (registered, 1-cycle read)
- `w_ready`  in  1  weights memory ready; qualifies `w` and `pixel_in`
- `pixel_in`  in  16 signed  pixel from input buffer for the previous cycle's `addr` (1-cycle registered read)
- `mem_en`  out  1  drives the weights memory `start` and the pixel buffer read enable
- `addr`  out  ADDR_W  input index driven to the weights memory `input_pixel_addr` and to the pixel buffer
- `result`  out  16 signed  saturated neuron output; held until the next result
- `result_valid`  out  1  one-cycle pulse when `result` updates
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle

## Operation
- FSM states: IDLE, ISSUE, ACC, FINAL, DONE.
- IDLE: `start`=1 → clear the accumulator and the issue and accept counters, latch `bias`, go to ISSUE. In every other state `start` is ignored.
- ISSUE: `mem_en`=1, `addr`=issue count (0..N_IN-1), issue count increments each cycle. After driving address N_IN-1, go to ACC with `mem_en`=0.
- Accumulate rule, in any state: on a cycle with `w_ready`=1 and accept count < N_IN, do acc += sign-extend(w*pixel_in) (32-bit product into ACC_W bits) and increment the accept count.
- ACC: wait until the accept count = N_IN, then go to FINAL. If fewer products have arrived, stay in ACC; there is no timeout.
- FINAL: compute t = (acc + (sign-extend(bias) <<< FRAC)) >>>  FRAC. The shift is arithmetic and floors.
  - If RELU and t<0, then t=0.
  - Saturate t to [-32768, 32767].
  - Register t into `result`. Go to DONE.
- DONE: `result_valid`=1 for this cycle only, then go to IDLE.
- `addr` holds its last value when `mem_en`=0. The returned `w`=0 at that point does not matter because accumulation is gated by `w_ready`.
- Reset (`rst_n`=0) at any time, including mid-operation:
  - state goes to IDLE; `mem_en`, `addr`, `result`, `result_valid`, `busy` and the accumulator go to 0;
  - any partial sum is discarded, and no `result_valid` is produced for the aborted operation.
- The accumulator width guarantees no overflow for N_IN ≤ 2^(ACC_W-32). No wrap-around checking is required inside the accumulator.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycles 1..N_IN: `mem_en`=1, `addr`=0..N_IN-1.
- Cycles 2..N_IN+1: `w_ready`=1 with `w[k]` and `pixel_in[k]`; products accepted.
- Cycle N_IN+2: FINAL.
- Cycle N_IN+3: `result_valid`=1.
- Latency from `start` to `result_valid` is N_IN+3 cycles (13 for N_IN=10).
- Earliest next `start` acceptance is cycle N_IN+4, so throughput is one result per N_IN+4 cycles.
- `busy` is high in cycles 1..N_IN+3.
- `result` changes only on the edge that enters DONE.

## Test plan
- Weights 20,16,22,16,18,19,18,16,15,19, all pixels 256, bias 0 → `result`=179, `result_valid` exactly one cycle, 13 cycles after `start`. `addr` sequence 0..9 with `mem_en` high for exactly 10 cycles.
- Same weights, all pixels -256, RELU=1 → `result`=0. Same stimulus with RELU=0 → `result`=-179.
- Same weights, all pixels 32767, bias 32000 → unsaturated value 22911+32000 is clamped, `result`=32767. Same with bias -32768 and pixels -32767, RELU=0 → `result`=-32768.
- `rst_n` pulsed low in cycle 5 of an operation → all outputs 0 immediately and no `result_valid`. A fresh `start` with the first test's stimulus → `result`=179.
- `start` held high continuously → results issued every 14 cycles, each 179. `start` pulses arriving while `busy`=1 do not restart or corrupt the operation.
- `w_ready` forced low for 3 cycles mid-stream by the bench's memory model, with product delivery delayed accordingly → FSM stays in ACC until 10 products are accepted. Final `result`=179 and `result_valid` is delayed by 3 cycles.

Source files
------------

// File: rtl/df_mac_unit.sv
// ---------------------------------------------------------------------------
// df_mac_unit
//
// Dot-product stage for one dense-layer neuron. It walks input indices
// 0..N_IN-1 and drives the weights memory and the pixel buffer. It
// accumulates w*pixel for every product the memories hand back. Then it
// folds in the bias, rescales by FRAC, optionally applies ReLU, saturates
// to 16 bits and presents one result with a single-cycle valid pulse.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request one dot product (only looked at while idle)
//   bias         signed bias in output Q-format, captured with start
//   w            signed weight returned by the weights memory
//   w_ready      qualifies w and pixel_in for the current cycle
//   pixel_in     signed pixel for the previous cycle's addr
//   mem_en       read enable for the weights memory and the pixel buffer
//   addr         input index being requested
//   result       saturated neuron output, held until the next result
//   result_valid one-cycle pulse in the cycle result is new
//   busy         high from the cycle after start through the DONE cycle
// ---------------------------------------------------------------------------
module df_mac_unit #(
    parameter int N_IN   = 10,
    parameter int ADDR_W = 4,
    parameter int ACC_W  = 40,
    parameter int FRAC   = 8,
    parameter int RELU   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [15:0]  bias,
    input  logic signed [15:0]  w,
    input  logic                w_ready,
    input  logic signed [15:0]  pixel_in,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   addr,
    output logic signed [15:0]  result,
    output logic                result_valid,
    output logic                busy
);

    // The accept counter has to reach N_IN itself, so it needs one bit more
    // than the address.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]        N_CNT     = CNT_W'(N_IN);
    localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(N_IN - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN   = ACC_W'(-32768);
    localparam logic signed [ACC_W-1:0] ZERO      = '0;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ACC,
        FINAL,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [CNT_W-1:0]          acceptCnt_q, acceptCnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [15:0]        bias_q, bias_d;
    logic signed [15:0]        result_q, result_d;

    logic signed [31:0]        product;
    logic signed [ACC_W-1:0]   productExt;
    logic signed [ACC_W-1:0]   biasScaled;
    logic signed [ACC_W-1:0]   sumWide;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [15:0]        satValue;

    assign product    = w * pixel_in;
    assign productExt = {{(ACC_W-32){product[31]}}, product};

    // Post-processing of the finished sum. The bias is lifted into the
    // accumulator's fixed-point scale before the add. The arithmetic right
    // shift then floors. ReLU is applied before saturation, so with ReLU
    // enabled only the upper clamp can ever fire.
    always_comb begin
        biasScaled = {{(ACC_W-16){bias_q[15]}}, bias_q} <<< FRAC;
        sumWide    = acc_q + biasScaled;
        shifted    = sumWide >>> FRAC;
        if ((RELU != 0) && (shifted < ZERO)) begin
            shifted = ZERO;
        end
        if (shifted > SAT_MAX) begin
            satValue = 16'sh7fff;
        end else if (shifted < SAT_MIN) begin
            satValue = 16'sh8000;
        end else begin
            satValue = shifted[15:0];
        end
    end

    // Next-state and datapath update. Products are accepted in every state
    // whenever the memory flags one as ready, up to N_IN of them. The ACC
    // exit looks at the post-update count, so the last product and the move
    // to FINAL happen in the same cycle. Clearing on start overrides any
    // product that lands in that same cycle.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        acceptCnt_d = acceptCnt_q;
        acc_d       = acc_q;
        bias_d      = bias_q;
        result_d    = result_q;

        if (w_ready && (acceptCnt_q < N_CNT)) begin
            acc_d       = acc_q + productExt;
            acceptCnt_d = acceptCnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ISSUE;
                    addr_d      = '0;
                    acceptCnt_d = '0;
                    acc_d       = '0;
                    bias_d      = bias;
                end
            end
            ISSUE: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ACC;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ACC: begin
                if (acceptCnt_d == N_CNT) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                result_d = satValue;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset discards any partial operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            acceptCnt_q <= '0;
            acc_q       <= '0;
            bias_q      <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            acceptCnt_q <= acceptCnt_d;
            acc_q       <= acc_d;
            bias_q      <= bias_d;
            result_q    <= result_d;
        end
    end

    // Outputs are decoded from the state register, so they are glitch-free.
    // They all fall to zero together when reset asserts.
    assign mem_en       = (state_q == ISSUE);
    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE);
    assign addr         = addr_q;
    assign result       = result_q;

endmodule

// File: tb/tb_df_mac_unit.sv
// ---------------------------------------------------------------------------
// tb_df_mac_unit
//
// Drives two copies of df_mac_unit from the same stimulus: one with ReLU
// and one without. A small memory model answers the address stream one
// cycle later and can insert a stall. Expected results come from plain
// integer arithmetic on the weights, pixels and bias.
// ---------------------------------------------------------------------------
module tb_df_mac_unit;

    localparam int N_IN    = 10;
    localparam int RUN_LEN = 24;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic signed [15:0] bias;
    logic signed [15:0] w;
    logic               w_ready;
    logic signed [15:0] pixel_in;

    logic               memEnR, memEnN;
    logic [3:0]         addrR, addrN;
    logic signed [15:0] resultR, resultN;
    logic               validR, validN;
    logic               busyR, busyN;

    int testsRun    = 0;
    int testsFailed = 0;

    int memW [N_IN];
    int memP [N_IN];
    int reqQ [$];
    int stallAt   = -1;
    int stallLeft = 0;
    int delivered = 0;

    typedef struct {
        string name;
        int    pixVal;
        int    biasVal;
        int    expRelu;
        int    expLin;
        int    stallPos;
        int    expLat;
    } vec_t;

    vec_t vecs [5];
    int   baseW [N_IN] = '{20, 16, 22, 16, 18, 19, 18, 16, 15, 19};

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    df_mac_unit #(
        .N_IN(10), .ADDR_W(4), .ACC_W(40), .FRAC(8), .RELU(1)
    ) dutRelu (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .w(w),
        .w_ready(w_ready), .pixel_in(pixel_in), .mem_en(memEnR),
        .addr(addrR), .result(resultR), .result_valid(validR), .busy(busyR)
    );

    df_mac_unit #(
        .N_IN(10), .ADDR_W(4), .ACC_W(40), .FRAC(8), .RELU(0)
    ) dutLin (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .w(w),
        .w_ready(w_ready), .pixel_in(pixel_in), .mem_en(memEnN),
        .addr(addrN), .result(resultN), .result_valid(validN), .busy(busyN)
    );

    // One comparison: count it and report a mismatch.
    task automatic checkOutput(input string name, input longint actual,
                               input longint expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Expected neuron output from the arithmetic definition: dot product
    // plus the scaled bias, floor-divided by 2^8, then ReLU, then the
    // 16-bit clamp.
    function automatic longint refModel(input int biasVal, input bit relu);
        longint num = 0;
        longint t;
        for (int i = 0; i < N_IN; i++) begin
            num += longint'(memW[i]) * longint'(memP[i]);
        end
        num += longint'(biasVal) * 256;
        if (num >= 0) t = num / 256;
        else          t = -((-num + 255) / 256);
        if (relu && t < 0) t = 0;
        if (t > 32767)       t = 32767;
        else if (t < -32768) t = -32768;
        return t;
    endfunction

    // Advance one clock. Just after the edge the memory model presents the
    // data for the address seen in the previous cycle, or a stall bubble.
    // At the falling edge it records this cycle's request.
    task automatic stepCycle();
        int a;
        @(posedge clk);
        #1;
        if (stallAt >= 0 && delivered == stallAt && reqQ.size() > 0) begin
            stallLeft = 3;
            stallAt   = -1;
        end
        if (stallLeft > 0) begin
            w_ready  = 1'b0;
            w        = '0;
            pixel_in = '0;
            stallLeft--;
        end else if (reqQ.size() > 0) begin
            a        = reqQ.pop_front();
            w_ready  = 1'b1;
            w        = 16'(memW[a]);
            pixel_in = 16'(memP[a]);
            delivered++;
        end else begin
            w_ready  = 1'b0;
            w        = '0;
            pixel_in = '0;
        end
        @(negedge clk);
        if (memEnR) reqQ.push_back(int'(addrR));
    endtask

    // Run one full dot product from a start pulse. Watch the address
    // stream, busy and the valid pulse for a fixed window, then check
    // everything. Cycle 0 is the cycle in which start is sampled.
    task automatic applyStimulus(input string name, input int biasVal,
                                 input int expRelu, input int expLin,
                                 input int stallPos, input int expLat);
        int     memEnCount = 0;
        int     addrErr    = 0;
        int     busyErr    = 0;
        int     validCount = 0;
        int     validCycle = -1;
        int     nextAddr   = 0;
        longint gotR       = 99999;
        longint gotN       = 99999;
        longint holdR      = 99999;
        stallAt   = stallPos;
        delivered = 0;
        bias      = 16'(biasVal);
        start     = 1'b1;
        stepCycle();
        start = 1'b0;
        bias  = 16'sh1234;
        for (int c = 1; c <= RUN_LEN; c++) begin
            if (memEnR) begin
                memEnCount++;
                if (int'(addrR) != nextAddr) addrErr++;
                nextAddr++;
            end
            if (memEnN != memEnR || addrN != addrR) addrErr++;
            if (validR) begin
                validCount++;
                if (validCycle < 0) begin
                    validCycle = c;
                    gotR       = longint'(resultR);
                    gotN       = longint'(resultN);
                end
            end
            if (validN != validR || busyN != busyR) busyErr++;
            if (c <= expLat && !busyR) busyErr++;
            if (c == expLat + 1 && busyR) busyErr++;
            if (c == RUN_LEN) holdR = longint'(resultR);
            stepCycle();
        end
        checkOutput({name, " relu result"}, gotR, longint'(expRelu));
        checkOutput({name, " linear result"}, gotN, longint'(expLin));
        checkOutput({name, " latency"}, validCycle, expLat);
        checkOutput({name, " valid pulses"}, validCount, 1);
        checkOutput({name, " mem_en cycles"}, memEnCount, N_IN);
        checkOutput({name, " addr errors"}, addrErr, 0);
        checkOutput({name, " busy errors"}, busyErr, 0);
        checkOutput({name, " result hold"}, holdR, longint'(expRelu));
    endtask

    // Main test sequence
    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        bias     = '0;
        w        = '0;
        w_ready  = 1'b0;
        pixel_in = '0;

        vecs[0] = '{"pos256",  256,     0,    179,    179, -1, 13};
        vecs[1] = '{"neg256", -256,     0,      0,   -179, -1, 13};
        vecs[2] = '{"satHi",  32767, 32000, 32767,  32767, -1, 13};
        vecs[3] = '{"satLo", -32767, -32768,    0, -32768, -1, 13};
        vecs[4] = '{"stall",   256,     0,    179,    179,  4, 16};

        // Outputs under reset
        repeat (3) @(negedge clk);
        checkOutput("reset mem_en", memEnR, 0);
        checkOutput("reset addr", addrR, 0);
        checkOutput("reset result", resultR, 0);
        checkOutput("reset valid", validR, 0);
        checkOutput("reset busy", busyR, 0);
        rst_n = 1'b1;
        stepCycle();
        stepCycle();

        // Directed vectors from the table
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < N_IN; i++) begin
                memW[i] = baseW[i];
                memP[i] = vecs[v].pixVal;
            end
            applyStimulus(vecs[v].name, vecs[v].biasVal, vecs[v].expRelu,
                          vecs[v].expLin, vecs[v].stallPos, vecs[v].expLat);
        end

        // Reset in cycle 5 of an operation, then a clean rerun
        begin
            int validSeen = 0;
            for (int i = 0; i < N_IN; i++) begin
                memW[i] = baseW[i];
                memP[i] = 256;
            end
            stallAt   = -1;
            delivered = 0;
            bias      = '0;
            start     = 1'b1;
            stepCycle();
            start = 1'b0;
            repeat (4) stepCycle();
            rst_n = 1'b0;
            reqQ.delete();
            #1;
            checkOutput("midreset mem_en", memEnR, 0);
            checkOutput("midreset addr", addrR, 0);
            checkOutput("midreset result", resultR, 0);
            checkOutput("midreset valid", validR, 0);
            checkOutput("midreset busy", busyR, 0);
            stepCycle();
            rst_n = 1'b1;
            for (int c = 0; c < 20; c++) begin
                if (validR || validN) validSeen++;
                stepCycle();
            end
            checkOutput("midreset no valid", validSeen, 0);
            applyStimulus("after reset", 0, 179, 179, -1, 13);
        end

        // start held high: restarts are ignored while busy, and a new
        // result appears every 14 cycles
        begin
            int     validCycles [$];
            longint vals [$];
            delivered = 0;
            stallAt   = -1;
            bias      = '0;
            start     = 1'b1;
            stepCycle();
            for (int c = 1; c <= 40; c++) begin
                if (validR) begin
                    validCycles.push_back(c);
                    vals.push_back(longint'(resultR));
                end
                stepCycle();
            end
            start = 1'b0;
            repeat (20) stepCycle();
            checkOutput("held start result count", validCycles.size(), 2);
            if (validCycles.size() >= 2) begin
                checkOutput("held start first latency", validCycles[0], 13);
                checkOutput("held start period", validCycles[1] - validCycles[0], 14);
                checkOutput("held start value 0", vals[0], 179);
                checkOutput("held start value 1", vals[1], 179);
            end
        end

        // Randomised vectors against the arithmetic model
        for (int r = 0; r < 8; r++) begin
            int biasVal;
            int sp;
            for (int i = 0; i < N_IN; i++) begin
                if (r % 2 == 0) begin
                    memW[i] = $urandom_range(0, 400) - 200;
                    memP[i] = $urandom_range(0, 4000) - 2000;
                end else begin
                    memW[i] = int'($signed(16'($urandom)));
                    memP[i] = int'($signed(16'($urandom)));
                end
            end
            biasVal = int'($signed(16'($urandom)));
            if (r % 3 == 0) biasVal = biasVal / 64;
            sp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : -1;
            applyStimulus($sformatf("random %0d", r), biasVal,
                          int'(refModel(biasVal, 1'b1)),
                          int'(refModel(biasVal, 1'b0)),
                          sp, (sp < 0) ? 13 : 16);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
